// File: rtl/highlight_cursor_controller_pkg.sv
// Shared encodings for the highlight cursor controller: event codes, FSM states
// and product grid geometry.
package highlight_cursor_controller_pkg;

  localparam int GRID_COLS  = 4;
  localparam int GRID_ROWS  = 3;
  localparam int N_PRODUCTS = 12;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_LEFT   = 3'd1;
  localparam logic [2:0] EV_RIGHT  = 3'd2;
  localparam logic [2:0] EV_UP     = 3'd3;
  localparam logic [2:0] EV_DOWN   = 3'd4;
  localparam logic [2:0] EV_SELECT = 3'd5;

  typedef enum logic {
    HIDDEN = 1'b0,
    SHOWN  = 1'b1
  } state_e;

endpackage

// File: rtl/highlight_cursor_controller_key_debouncer.sv
// One push-button: 2-FF synchroniser, press debounce with a single accept pulse,
// and re-arm only after the button has been stably released.
module highlight_cursor_controller_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEB_CNT_WIDTH   = 18
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic accept_o
);

  localparam logic [DEB_CNT_WIDTH-1:0] CNT_LAST = DEB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_CNT_WIDTH-1:0] CNT_ONE  = DEB_CNT_WIDTH'(1);

  logic                     sync1_q, sync2_q;
  logic                     armed_q;
  logic                     accept_q;
  logic [DEB_CNT_WIDTH-1:0] cnt_q;

  // Armed: count consecutive low cycles toward an accept.
  // Disarmed: count consecutive high cycles toward re-arm. Any level change restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      armed_q  <= 1'b1;
      accept_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      accept_q <= 1'b0;
      if (armed_q) begin
        if (!sync2_q) begin
          if (cnt_q == CNT_LAST) begin
            accept_q <= 1'b1;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end else begin
          cnt_q <= '0;
        end
      end else begin
        if (sync2_q) begin
          if (cnt_q == CNT_LAST) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign accept_o = accept_q;

endmodule

// File: rtl/highlight_cursor_controller.sv
// Button-driven cursor over the product grid; cursor changes commit only on
// FRAME_START so the VGA highlight never tears, and the cursor hides when idle.
module highlight_cursor_controller #(
  parameter int GRID_COLS           = highlight_cursor_controller_pkg::GRID_COLS,
  parameter int GRID_ROWS           = highlight_cursor_controller_pkg::GRID_ROWS,
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int DEB_CNT_WIDTH       = 18,
  parameter int IDLE_TIMEOUT_FRAMES = 600
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        KEY_LEFT,
  input  logic        KEY_RIGHT,
  input  logic        KEY_UP,
  input  logic        KEY_DOWN,
  input  logic        KEY_SELECT,
  input  logic        FRAME_START,
  output logic [11:0] HighlightedProductList,
  output logic [3:0]  CursorIndex,
  output logic        CursorVisible,
  output logic        SelectPulse,
  output logic [3:0]  SelectedIndex
);

  import highlight_cursor_controller_pkg::*;

  localparam int COL_W  = $clog2(GRID_COLS);
  localparam int ROW_W  = $clog2(GRID_ROWS);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT_FRAMES + 1);

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(GRID_ROWS - 1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_TIMEOUT_FRAMES - 1);
  localparam logic [N_PRODUCTS-1:0] LIST_ONE = N_PRODUCTS'(1);

  logic [4:0] accept;
  logic [2:0] acc_ev;

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic [2:0]              pending_q, pending_d;
  logic [3:0]              idx_q, idx_d;
  logic [N_PRODUCTS-1:0]   list_q, list_d;
  logic                    sel_pulse_q, sel_pulse_d;
  logic [3:0]              sel_idx_q, sel_idx_d;

  highlight_cursor_controller_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_CNT_WIDTH(DEB_CNT_WIDTH)
  ) u_deb_left (.clk_i(CLOCK), .rst_ni(RESET_N), .key_n_i(KEY_LEFT), .accept_o(accept[0]));
  highlight_cursor_controller_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_CNT_WIDTH(DEB_CNT_WIDTH)
  ) u_deb_right (.clk_i(CLOCK), .rst_ni(RESET_N), .key_n_i(KEY_RIGHT), .accept_o(accept[1]));
  highlight_cursor_controller_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_CNT_WIDTH(DEB_CNT_WIDTH)
  ) u_deb_up (.clk_i(CLOCK), .rst_ni(RESET_N), .key_n_i(KEY_UP), .accept_o(accept[2]));
  highlight_cursor_controller_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_CNT_WIDTH(DEB_CNT_WIDTH)
  ) u_deb_down (.clk_i(CLOCK), .rst_ni(RESET_N), .key_n_i(KEY_DOWN), .accept_o(accept[3]));
  highlight_cursor_controller_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DEB_CNT_WIDTH(DEB_CNT_WIDTH)
  ) u_deb_select (.clk_i(CLOCK), .rst_ni(RESET_N), .key_n_i(KEY_SELECT), .accept_o(accept[4]));

  always_comb begin
    acc_ev = EV_NONE;
    if (accept[4])      acc_ev = EV_SELECT;
    else if (accept[0]) acc_ev = EV_LEFT;
    else if (accept[1]) acc_ev = EV_RIGHT;
    else if (accept[2]) acc_ev = EV_UP;
    else if (accept[3]) acc_ev = EV_DOWN;
  end

  // The pending slot consumed on FRAME_START is the value held before this cycle,
  // so an accept landing on FRAME_START waits for the next frame.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    idle_d      = idle_q;
    sel_pulse_d = 1'b0;
    sel_idx_d   = sel_idx_q;
    pending_d   = (acc_ev != EV_NONE) ? acc_ev : pending_q;
    if (FRAME_START) begin
      pending_d = acc_ev;
      case (state_q)
        HIDDEN: begin
          if (pending_q != EV_NONE) begin
            state_d = SHOWN;
            idle_d  = '0;
          end
        end
        SHOWN: begin
          idle_d = '0;
          case (pending_q)
            EV_LEFT:   col_d = (col_q == '0)      ? COL_MAX : col_q - COL_ONE;
            EV_RIGHT:  col_d = (col_q == COL_MAX) ? '0      : col_q + COL_ONE;
            EV_UP:     row_d = (row_q == '0)      ? ROW_MAX : row_q - ROW_ONE;
            EV_DOWN:   row_d = (row_q == ROW_MAX) ? '0      : row_q + ROW_ONE;
            EV_SELECT: begin
              sel_pulse_d = 1'b1;
              sel_idx_d   = idx_q;
            end
            default: begin
              // Counter stops at the timeout, so it can never wrap.
              if (idle_q >= IDLE_END) begin
                state_d = HIDDEN;
                idle_d  = '0;
              end else begin
                idle_d = idle_q + IDLE_ONE;
              end
            end
          endcase
        end
        default: state_d = HIDDEN;
      endcase
    end
    idx_d  = 4'(row_d) * 4'(GRID_COLS) + 4'(col_d);
    list_d = (state_d == SHOWN) ? (LIST_ONE << idx_d) : '0;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= HIDDEN;
      row_q       <= '0;
      col_q       <= '0;
      idle_q      <= '0;
      pending_q   <= EV_NONE;
      idx_q       <= '0;
      list_q      <= '0;
      sel_pulse_q <= 1'b0;
      sel_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idle_q      <= idle_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      list_q      <= list_d;
      sel_pulse_q <= sel_pulse_d;
      sel_idx_q   <= sel_idx_d;
    end
  end

  assign HighlightedProductList = list_q;
  assign CursorIndex            = idx_q;
  assign CursorVisible          = (state_q == SHOWN);
  assign SelectPulse            = sel_pulse_q;
  assign SelectedIndex          = sel_idx_q;

endmodule
